// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - pipeline/syncram bundle for mem_port_arbiter
// Purpose: carries the IF read port, the data port, the syncram pins and busy
//   between the arbiter and its surroundings.
// Modports:
//   slave  - arbiter side: takes requests and ram_dout, drives grants, responses,
//            ram_* pins and busy.
//   master - environment side (pipeline stages plus syncram): the mirror image.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          ram_cs;
  logic          ram_oe;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_ack, d_rdata,
           ram_cs, ram_oe, ram_we, ram_addr, ram_din, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, ram_dout,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_ack, d_rdata,
           ram_cs, ram_oe, ram_we, ram_addr, ram_din, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one syncram between the IF and data ports
// Purpose: arbitrates the instruction-fetch read port and the data port onto a
//   single syncram. One access every 3 cycles (IDLE -> ACC -> RSP). All syncram
//   pins and all responses are driven from registers.
// Ports:
//   clk   - clock, all state changes on posedge
//   rst_n - asynchronous active-low reset
//   bus   - mem_port_arbiter_if.slave: if_* read port, d_* data port,
//           ram_* syncram pins, busy (state != IDLE)
// Configuration macro: MEM_ARB_RR_EN
//   defined   - round-robin on contention (the port that lost last time wins)
//   undefined - data port has priority; IF is forced through after STARVE_MAX
//               consecutive contended losses
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, ACC, RSP} state_t;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t          state, state_n;
  logic [CNT_W-1:0] starve_q, starve_n;
  logic            cur_if_q, cur_if_n;   // port owning the access in flight
  logic            cur_we_q, cur_we_n;   // access in flight is a write
`ifdef MEM_ARB_RR_EN
  logic            last_win_q, last_win_n;  // 1 = IF won the previous grant
`endif

  logic            if_gnt_q, if_gnt_n;
  logic            d_gnt_q, d_gnt_n;
  logic            if_rvalid_q, if_rvalid_n;
  logic            d_ack_q, d_ack_n;
  logic [DW-1:0]   if_rdata_q, if_rdata_n;
  logic [DW-1:0]   d_rdata_q, d_rdata_n;
  logic            ram_cs_q, ram_cs_n;
  logic            ram_oe_q, ram_oe_n;
  logic            ram_we_q, ram_we_n;
  logic [AW-1:0]   ram_addr_q, ram_addr_n;
  logic [DW-1:0]   ram_din_q, ram_din_n;

  logic            win_if;
  logic            contend;

  always_comb begin
    state_n     = state;
    starve_n    = starve_q;
    cur_if_n    = cur_if_q;
    cur_we_n    = cur_we_q;
`ifdef MEM_ARB_RR_EN
    last_win_n  = last_win_q;
`endif
    // pulses and strobes fall back to 0 unless asserted below
    if_gnt_n    = 1'b0;
    d_gnt_n     = 1'b0;
    if_rvalid_n = 1'b0;
    d_ack_n     = 1'b0;
    ram_cs_n    = 1'b0;
    ram_oe_n    = 1'b0;
    ram_we_n    = 1'b0;
    if_rdata_n  = if_rdata_q;
    d_rdata_n   = d_rdata_q;
    ram_addr_n  = ram_addr_q;
    ram_din_n   = ram_din_q;
    win_if      = 1'b0;
    contend     = bus.if_req && bus.d_req;

    case (state)
      IDLE: begin
        if (bus.if_req || bus.d_req) begin
`ifdef MEM_ARB_RR_EN
          // last_win resets to IF, so the first contended grant goes to d
          win_if   = contend ? !last_win_q : bus.if_req;
          starve_n = '0;
`else
          if (contend) begin
            win_if = (starve_q == STARVE_LIM);
            if (win_if) begin
              starve_n = '0;
            end else if (starve_q != {CNT_W{1'b1}}) begin
              starve_n = starve_q + CNT_ONE;
            end
          end else begin
            win_if = bus.if_req;
          end
`endif
          state_n  = ACC;
          if_gnt_n = win_if;
          d_gnt_n  = !win_if;
          cur_if_n = win_if;
          cur_we_n = !win_if && bus.d_we;
          ram_cs_n = 1'b1;
          ram_we_n = !win_if && bus.d_we;
          ram_oe_n = !(!win_if && bus.d_we);
          ram_addr_n = win_if ? bus.if_addr : bus.d_addr;
          ram_din_n  = win_if ? '0 : bus.d_wdata;
`ifdef MEM_ARB_RR_EN
          last_win_n = win_if;
`endif
        end
      end
      ACC: begin
        // syncram samples the pins on this edge; strobes drop via defaults
        state_n = RSP;
      end
      RSP: begin
        state_n    = IDLE;
        ram_addr_n = '0;
        ram_din_n  = '0;
        if (cur_if_q) begin
          if_rvalid_n = 1'b1;
          if_rdata_n  = bus.ram_dout;
        end else begin
          d_ack_n = 1'b1;
          if (!cur_we_q) d_rdata_n = bus.ram_dout;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      starve_q    <= '0;
      cur_if_q    <= 1'b0;
      cur_we_q    <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_win_q  <= 1'b1;
`endif
      if_gnt_q    <= 1'b0;
      d_gnt_q     <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      ram_cs_q    <= 1'b0;
      ram_oe_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
    end else begin
      state       <= state_n;
      starve_q    <= starve_n;
      cur_if_q    <= cur_if_n;
      cur_we_q    <= cur_we_n;
`ifdef MEM_ARB_RR_EN
      last_win_q  <= last_win_n;
`endif
      if_gnt_q    <= if_gnt_n;
      d_gnt_q     <= d_gnt_n;
      if_rvalid_q <= if_rvalid_n;
      d_ack_q     <= d_ack_n;
      if_rdata_q  <= if_rdata_n;
      d_rdata_q   <= d_rdata_n;
      ram_cs_q    <= ram_cs_n;
      ram_oe_q    <= ram_oe_n;
      ram_we_q    <= ram_we_n;
      ram_addr_q  <= ram_addr_n;
      ram_din_q   <= ram_din_n;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_gnt     = d_gnt_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.ram_cs    = ram_cs_q;
  assign bus.ram_oe    = ram_oe_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE_MAX), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] init_val(logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // syncram: pins registered on posedge, dout registered
  logic [31:0] sram [logic [31:0]];
  logic [31:0] refm [logic [31:0]];

  function automatic logic [31:0] sram_rd(logic [31:0] a);
    return sram.exists(a) ? sram[a] : init_val(a);
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return refm.exists(a) ? refm[a] : init_val(a);
  endfunction

  initial bus.ram_dout = '0;
  always @(posedge clk) begin
    if (bus.ram_cs) begin
      if (bus.ram_we) sram[bus.ram_addr] = bus.ram_din;
      else if (bus.ram_oe) bus.ram_dout <= sram_rd(bus.ram_addr);
    end
  end

  // reference model: transaction-level arbitration and memory
  typedef struct {
    bit          is_if;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } gnt_t;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
  } rsp_t;

  gnt_t gnt_q[$];
  rsp_t rsp_q[$];
  bit   grant_log[$];
  bit   mon_en = 1'b0;
  int   m_busy = 0;
  int   m_starve = 0;
  logic [31:0] m_last_d = '0;

  // the arbiter accepts a new request once every 3 cycles
  always @(negedge clk) begin
    if (mon_en) begin
      if (m_busy > 0) begin
        m_busy--;
      end else if (bus.if_req || bus.d_req) begin
        gnt_t g;
        rsp_t r;
        bit   wi;
        if (bus.if_req && bus.d_req) begin
          if (m_starve == STARVE_MAX) begin
            wi = 1'b1;
            m_starve = 0;
          end else begin
            wi = 1'b0;
            m_starve = (m_starve < 7) ? m_starve + 1 : 7;
          end
        end else begin
          wi = bus.if_req;
        end
        g.is_if = wi;
        g.we    = !wi && bus.d_we;
        g.addr  = wi ? bus.if_addr : bus.d_addr;
        g.wdata = wi ? 32'h0 : bus.d_wdata;
        r.is_if = wi;
        if (wi) begin
          r.data = ref_rd(g.addr);
        end else if (g.we) begin
          refm[g.addr] = g.wdata;
          r.data = m_last_d;
        end else begin
          r.data = ref_rd(g.addr);
          m_last_d = r.data;
        end
        gnt_q.push_back(g);
        rsp_q.push_back(r);
        m_busy = 2;
      end
    end
  end

  // monitor: compares DUT outputs against the queued expectations
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.if_gnt || bus.d_gnt) begin
        check("gnt_onehot", {63'b0, bus.if_gnt && bus.d_gnt}, 64'd0);
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 64'd1, 64'd0);
        end else begin
          gnt_t e;
          e = gnt_q.pop_front();
          grant_log.push_back(bus.if_gnt);
          check("gnt_port", {63'b0, bus.if_gnt}, {63'b0, e.is_if});
          check("gnt_ram_cs", {63'b0, bus.ram_cs}, 64'd1);
          check("gnt_ram_we", {63'b0, bus.ram_we}, {63'b0, e.we});
          check("gnt_ram_oe", {63'b0, bus.ram_oe}, {63'b0, !e.we});
          check("gnt_ram_addr", {32'b0, bus.ram_addr}, {32'b0, e.addr});
          check("gnt_ram_din", {32'b0, bus.ram_din}, {32'b0, e.wdata});
        end
      end
      if (bus.if_rvalid || bus.d_ack) begin
        if (rsp_q.size() == 0) begin
          check("rsp_unexpected", 64'd1, 64'd0);
        end else begin
          rsp_t e;
          e = rsp_q.pop_front();
          check("rsp_port", {63'b0, bus.if_rvalid}, {63'b0, e.is_if});
          if (e.is_if) check("if_rdata", {32'b0, bus.if_rdata}, {32'b0, e.data});
          else check("d_rdata", {32'b0, bus.d_rdata}, {32'b0, e.data});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    clear_inputs();
    rst_n = 1'b0;
    gnt_q.delete();
    rsp_q.delete();
    grant_log.delete();
    m_busy = 0;
    m_starve = 0;
    m_last_d = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic drv_if(input int n_txn, input int max_gap);
    int done = 0;
    int gap = 0;
    int cyc = 0;
    while (done < n_txn && cyc < 4000) begin
      tick();
      cyc++;
      if (bus.if_req && bus.if_gnt) begin
        bus.if_req = 1'b0;
        done++;
        gap = $urandom_range(0, max_gap);
      end else if (!bus.if_req) begin
        if (gap == 0) begin
          bus.if_req  = 1'b1;
          bus.if_addr = 32'($urandom_range(0, 15)) << 2;
        end else begin
          gap--;
        end
      end
    end
    bus.if_req = 1'b0;
    check("if_driver_done", 64'(done), 64'(n_txn));
  endtask

  task automatic drv_d(input int n_txn, input int max_gap);
    int done = 0;
    int gap = 0;
    int cyc = 0;
    while (done < n_txn && cyc < 4000) begin
      tick();
      cyc++;
      if (bus.d_req && bus.d_gnt) begin
        bus.d_req = 1'b0;
        done++;
        gap = $urandom_range(0, max_gap);
      end else if (!bus.d_req) begin
        if (gap == 0) begin
          bus.d_req   = 1'b1;
          bus.d_we    = 1'($urandom_range(0, 1));
          bus.d_addr  = 32'($urandom_range(0, 15)) << 2;
          bus.d_wdata = $urandom;
        end else begin
          gap--;
        end
      end
    end
    bus.d_req = 1'b0;
    check("d_driver_done", 64'(done), 64'(n_txn));
  endtask

  // directed single data access with its own timing checks
  task automatic d_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    bus.d_req = 1'b1;
    bus.d_we = we;
    bus.d_addr = addr;
    bus.d_wdata = wdata;
    n = 0;
    do begin tick(); n++; end while (!bus.d_gnt && n < 8);
    check("d_gnt_latency", 64'(n), 64'd1);
    bus.d_req = 1'b0;
    n = 0;
    do begin tick(); n++; end while (!bus.d_ack && n < 8);
    check("d_ack_latency", 64'(n), 64'd2);
  endtask

  logic [63:0] outs;
  always_comb outs = {63'b0, |{bus.if_gnt, bus.if_rvalid, bus.if_rdata, bus.d_gnt, bus.d_ack,
                              bus.d_rdata, bus.ram_cs, bus.ram_oe, bus.ram_we, bus.ram_addr,
                              bus.ram_din, bus.busy}};

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    int cs_cnt;
    bit pat [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    clear_inputs();
    sram[32'h0] = 32'h2001_0005;
    refm[32'h0] = 32'h2001_0005;
    #3;
    check("reset_outputs", outs, 64'd0);
    do_reset();
    mon_en = 1'b0;

    // IF-only read
    bus.if_req = 1'b1;
    bus.if_addr = 32'h0;
    n = 0;
    do begin tick(); n++; end while (!bus.if_gnt && n < 8);
    check("if_gnt_latency", 64'(n), 64'd1);
    bus.if_req = 1'b0;
    check("busy_in_acc", {63'b0, bus.busy}, 64'd1);
    n = 0;
    do begin tick(); n++; end while (!bus.if_rvalid && n < 8);
    check("if_rvalid_latency", 64'(n), 64'd2);
    check("if_rdata_0x0", {32'b0, bus.if_rdata}, 64'h2001_0005);
    tick();
    check("if_rvalid_pulse", {63'b0, bus.if_rvalid}, 64'd0);
    check("busy_idle", {63'b0, bus.busy}, 64'd0);

    // data write then read
    d_access(1'b1, 32'h40, 32'hDEAD_BEEF);
    refm[32'h40] = 32'hDEAD_BEEF;
    check("d_rdata_after_write", {32'b0, bus.d_rdata}, 64'd0);
    tick();
    d_access(1'b0, 32'h40, 32'h0);
    check("d_rdata_after_read", {32'b0, bus.d_rdata}, 64'hDEAD_BEEF);
    tick();

    // withdraw: IF requests only while the arbiter is busy
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h8;
    tick();
    cs_cnt = bus.ram_cs ? 1 : 0;
    bus.d_req = 1'b0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h4;
    seen = 1'b0;
    tick();
    bus.if_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.ram_cs) cs_cnt++;
      if (bus.if_gnt) seen = 1'b1;
      tick();
    end
    check("withdraw_cs_pulses", 64'(cs_cnt), 64'd1);
    check("withdraw_no_if_gnt", {63'b0, seen}, 64'd0);

    // reset in the middle of an IF read
    bus.if_req = 1'b1;
    bus.if_addr = 32'h10;
    tick();
    check("pre_reset_if_gnt", {63'b0, bus.if_gnt}, 64'd1);
    #2;
    rst_n = 1'b0;
    bus.if_req = 1'b0;
    #1;
    check("async_reset_outputs", outs, 64'd0);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus.if_rvalid) seen = 1'b1;
      tick();
    end
    check("no_rvalid_after_reset", {63'b0, seen}, 64'd0);
    check("busy_after_reset", {63'b0, bus.busy}, 64'd0);

    // contention with both requests held: starvation override pattern
    do_reset();
    fork
      drv_if(2, 0);
      drv_d(8, 0);
    join
    repeat (6) tick();
    check("contention_grants", 64'(grant_log.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      if (i < grant_log.size()) check($sformatf("contention_order_%0d", i),
                                      {63'b0, grant_log[i]}, {63'b0, pat[i]});
    end

    // randomized traffic against the reference model
    fork
      drv_if(40, 3);
      drv_d(40, 3);
    join
    repeat (8) tick();
    check("gnt_queue_drained", 64'(gnt_q.size()), 64'd0);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);

    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
